aurora_rx_packet_buffer: RTL and testbench

//  Receive-side consumer of the 32-bit Aurora user stream, in the auUserClk domain after RX downconversion.
//  The input has no back-pressure. Frames are stored in a circular buffer and released only after the CRC

---
 rtl/aurora_rx_packet_buffer_pkg.sv | 21 ++
 rtl/aurora_rx_packet_buffer_if.sv | 29 ++
 rtl/aurora_rx_packet_buffer_dpram.sv | 23 ++
 rtl/aurora_rx_packet_buffer.sv | 191 +++++++++++++++++++
 tb/tb_aurora_rx_packet_buffer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/aurora_rx_packet_buffer_pkg.sv
// Shared definitions for the Aurora RX packet buffer: tuser bit positions,
// write-FSM encodings and the stored-word layout.
package aurora_rx_packet_buffer_pkg;

    localparam int CRC_VALID_BIT = 1;
    localparam int CRC_PASS_BIT  = 0;
    localparam int WORD_W        = 37;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2
    } wr_state_e;

    typedef struct packed {
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } buf_word_t;

endpackage

// File: rtl/aurora_rx_packet_buffer_if.sv
// Stream bundle for the packet buffer: the non-stallable Aurora RX input
// and the flow-controlled AXI replay output.
interface aurora_rx_packet_buffer_if;

    logic [31:0] sAxiRxTdata;
    logic [3:0]  sAxiRxTkeep;
    logic [7:0]  sAxiRxTuser;
    logic        sAxiRxTlast;
    logic        sAxiRxTvalid;

    logic [31:0] mAxiTdata;
    logic [3:0]  mAxiTkeep;
    logic        mAxiTlast;
    logic        mAxiTvalid;
    logic        mAxiTready;

    modport slave (
        input  sAxiRxTdata, sAxiRxTkeep, sAxiRxTuser, sAxiRxTlast, sAxiRxTvalid,
        input  mAxiTready,
        output mAxiTdata, mAxiTkeep, mAxiTlast, mAxiTvalid
    );

    modport master (
        output sAxiRxTdata, sAxiRxTkeep, sAxiRxTuser, sAxiRxTlast, sAxiRxTvalid,
        output mAxiTready,
        input  mAxiTdata, mAxiTkeep, mAxiTlast, mAxiTvalid
    );

endinterface

// File: rtl/aurora_rx_packet_buffer_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, single
// clock, no reset on the array or read register.
module rx_pkt_dpram #(
    parameter int AW = 9,
    parameter int DW = 37
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/aurora_rx_packet_buffer.sv
// Store-and-forward RX frame buffer: frames are written speculatively and
// only become readable once their last beat carries a passing CRC verdict.
module aurora_rx_packet_buffer
    import aurora_rx_packet_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     auUserClk,
    input  logic                     auUserReset,
    aurora_rx_packet_buffer_if.slave bus,
    output logic [CNT_WIDTH-1:0]     goodCount,
    output logic [CNT_WIDTH-1:0]     crcErrCount,
    output logic [CNT_WIDTH-1:0]     dropCount,
    output logic [ADDR_WIDTH:0]      bufLevel
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

    wr_state_e state_q, state_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] commitPtr_q, commitPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] fetchPtr_q, fetchPtr_d;
    logic [CNT_WIDTH-1:0] good_q, good_d, crc_q, crc_d, drop_q, drop_d;

    logic      out_vld_q, out_vld_d, pf_vld_q, pf_vld_d, ram_vld_q;
    buf_word_t out_q, out_d, pf_q, pf_d, ram_rdata, in_word;

    logic [PW-1:0] free;
    logic          full, crc_ok, ram_we, rd_en, pop, fetch_avail;
    logic          good_inc, crc_inc, drop_inc;
    logic [1:0]    occ;
    logic          unused_tuser;

    assign unused_tuser = ^bus.sAxiRxTuser[7:2];

    assign free     = DEPTH - (wrPtr_q - rdPtr_q);
    assign full     = (free == '0);
    assign bufLevel = commitPtr_q - rdPtr_q;
    assign crc_ok   = bus.sAxiRxTuser[CRC_VALID_BIT] & bus.sAxiRxTuser[CRC_PASS_BIT];

    // keep only carries information on the last beat; earlier beats are full words
    assign in_word.last = bus.sAxiRxTlast;
    assign in_word.keep = bus.sAxiRxTlast ? bus.sAxiRxTkeep : 4'hF;
    assign in_word.data = bus.sAxiRxTdata;

    // Write FSM: IDLE and WRITE share the store path so a single-beat frame
    // goes straight from IDLE to commit/rewind.
    always_comb begin
        state_d     = state_q;
        wrPtr_d     = wrPtr_q;
        commitPtr_d = commitPtr_q;
        ram_we      = 1'b0;
        good_inc    = 1'b0;
        crc_inc     = 1'b0;
        drop_inc    = 1'b0;
        if (bus.sAxiRxTvalid) begin
            unique case (state_q)
                ST_IDLE, ST_WRITE: begin
                    if (full) begin
                        wrPtr_d = commitPtr_q;
                        if (bus.sAxiRxTlast) begin
                            drop_inc = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            state_d  = ST_DROP;
                        end
                    end else begin
                        ram_we = 1'b1;
                        if (!bus.sAxiRxTlast) begin
                            wrPtr_d = wrPtr_q + P_ONE;
                            state_d = ST_WRITE;
                        end else if (crc_ok) begin
                            wrPtr_d     = wrPtr_q + P_ONE;
                            commitPtr_d = wrPtr_q + P_ONE;
                            good_inc    = 1'b1;
                            state_d     = ST_IDLE;
                        end else begin
                            wrPtr_d = commitPtr_q;
                            crc_inc = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (bus.sAxiRxTlast) begin
                        drop_inc = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        good_d = (good_inc && !(&good_q)) ? good_q + C_ONE : good_q;
        crc_d  = (crc_inc  && !(&crc_q))  ? crc_q  + C_ONE : crc_q;
        drop_d = (drop_inc && !(&drop_q)) ? drop_q + C_ONE : drop_q;
    end

    // Read side: fetchPtr runs ahead of rdPtr by the words sitting in the
    // RAM read stage, prefetch and output registers; rdPtr moves on handshake.
    assign pop         = out_vld_q & bus.mAxiTready;
    assign fetch_avail = (fetchPtr_q != commitPtr_q);
    assign occ         = 2'(out_vld_q) + 2'(pf_vld_q) + 2'(ram_vld_q) - 2'(pop);
    assign rd_en       = fetch_avail && (occ < 2'd2);
    assign fetchPtr_d  = rd_en ? fetchPtr_q + P_ONE : fetchPtr_q;
    assign rdPtr_d     = pop ? rdPtr_q + P_ONE : rdPtr_q;

    always_comb begin
        out_vld_d = out_vld_q;
        out_d     = out_q;
        pf_vld_d  = pf_vld_q;
        pf_d      = pf_q;
        if (pop || !out_vld_q) begin
            if (pf_vld_q) begin
                out_vld_d = 1'b1;
                out_d     = pf_q;
                pf_vld_d  = ram_vld_q;
                pf_d      = ram_rdata;
            end else if (ram_vld_q) begin
                out_vld_d = 1'b1;
                out_d     = ram_rdata;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (ram_vld_q) begin
            pf_vld_d = 1'b1;
            pf_d     = ram_rdata;
        end
    end

    always_ff @(posedge auUserClk or posedge auUserReset) begin
        if (auUserReset) begin
            state_q     <= ST_IDLE;
            wrPtr_q     <= '0;
            commitPtr_q <= '0;
            rdPtr_q     <= '0;
            fetchPtr_q  <= '0;
            good_q      <= '0;
            crc_q       <= '0;
            drop_q      <= '0;
            out_vld_q   <= 1'b0;
            out_q       <= '0;
            pf_vld_q    <= 1'b0;
            pf_q        <= '0;
            ram_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            commitPtr_q <= commitPtr_d;
            rdPtr_q     <= rdPtr_d;
            fetchPtr_q  <= fetchPtr_d;
            good_q      <= good_d;
            crc_q       <= crc_d;
            drop_q      <= drop_d;
            out_vld_q   <= out_vld_d;
            out_q       <= out_d;
            pf_vld_q    <= pf_vld_d;
            pf_q        <= pf_d;
            ram_vld_q   <= rd_en;
        end
    end

    rx_pkt_dpram #(
        .AW (ADDR_WIDTH),
        .DW (WORD_W)
    ) u_ram (
        .clk     (auUserClk),
        .we_i    (ram_we),
        .waddr_i (wrPtr_q[ADDR_WIDTH-1:0]),
        .wdata_i (in_word),
        .re_i    (rd_en),
        .raddr_i (fetchPtr_q[ADDR_WIDTH-1:0]),
        .rdata_o (ram_rdata)
    );

    assign bus.mAxiTvalid = out_vld_q;
    assign bus.mAxiTdata  = out_q.data;
    assign bus.mAxiTkeep  = out_q.keep;
    assign bus.mAxiTlast  = out_q.last;
    assign goodCount      = good_q;
    assign crcErrCount    = crc_q;
    assign dropCount      = drop_q;

endmodule

// File: tb/tb_aurora_rx_packet_buffer.sv
// Scoreboard bench for aurora_rx_packet_buffer at ADDR_WIDTH=4 (16 words).
module tb_aurora_rx_packet_buffer;
    import aurora_rx_packet_buffer_pkg::*;

    localparam int AW = 4;
    localparam int CW = 16;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aurora_rx_packet_buffer_if bus();
    logic [CW-1:0] goodCount, crcErrCount, dropCount;
    logic [AW:0]   bufLevel;

    aurora_rx_packet_buffer #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .auUserClk   (clk),
        .auUserReset (rst),
        .bus         (bus),
        .goodCount   (goodCount),
        .crcErrCount (crcErrCount),
        .dropCount   (dropCount),
        .bufLevel    (bufLevel)
    );

    buf_word_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    bit  rand_rdy = 1'b0;
    int  cyc = 0;
    bit  hold_v = 1'b0;
    buf_word_t hold_w;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks hold stability
    always @(negedge clk) begin
        buf_word_t got;
        got = {bus.mAxiTlast, bus.mAxiTkeep, bus.mAxiTdata};
        if (rst) begin
            hold_v <= 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 64'(bus.mAxiTvalid), 64'd1);
                check("hold_word", 64'(got), 64'(hold_w));
            end
            if (bus.mAxiTvalid && bus.mAxiTready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h expected none", got);
                end else begin
                    check("out_word", 64'(got), 64'(exp_q.pop_front()));
                end
            end
            hold_v <= bus.mAxiTvalid && !bus.mAxiTready;
            hold_w <= got;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rand_rdy) bus.mAxiTready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            tick();
            bus.sAxiRxTvalid = 1'b0;
            bus.sAxiRxTlast  = 1'b0;
        end
    endtask

    // term=0 sends len beats with no tlast (an interrupted frame)
    task automatic send_frame(int len, logic [31:0] base, logic [1:0] crc,
                              logic [3:0] lkeep, bit pass, bit term);
        for (int i = 0; i < len; i++) begin
            buf_word_t w;
            tick();
            w.last = term && (i == len - 1);
            w.keep = w.last ? lkeep : 4'hF;
            w.data = base + 32'(i);
            bus.sAxiRxTvalid = 1'b1;
            bus.sAxiRxTdata  = w.data;
            bus.sAxiRxTkeep  = lkeep;
            bus.sAxiRxTlast  = w.last;
            bus.sAxiRxTuser  = w.last ? {6'($urandom_range(0, 63)), crc} : 8'($urandom);
            if (pass) exp_q.push_back(w);
        end
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        bus.sAxiRxTvalid = 1'b0;
        bus.sAxiRxTlast  = 1'b0;
        exp_q.delete();
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic drain(string name, int max);
        int n = 0;
        idle(1);
        while ((exp_q.size() != 0 || bufLevel != 0 || bus.mAxiTvalid) && n < max) begin
            idle(1);
            n++;
        end
        check({name, "_drained"}, 64'(n < max), 64'd1);
    endtask

    task automatic check_zero(string name);
        check({name, "_valid"}, 64'(bus.mAxiTvalid), 64'd0);
        check({name, "_data"}, 64'(bus.mAxiTdata), 64'd0);
        check({name, "_keep"}, 64'(bus.mAxiTkeep), 64'd0);
        check({name, "_last"}, 64'(bus.mAxiTlast), 64'd0);
        check({name, "_level"}, 64'(bufLevel), 64'd0);
        check({name, "_good"}, 64'(goodCount), 64'd0);
        check({name, "_crc"}, 64'(crcErrCount), 64'd0);
        check({name, "_drop"}, 64'(dropCount), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_good, exp_bad;
        bus.sAxiRxTvalid = 1'b0;
        bus.sAxiRxTlast  = 1'b0;
        bus.sAxiRxTdata  = '0;
        bus.sAxiRxTkeep  = '0;
        bus.sAxiRxTuser  = '0;
        bus.mAxiTready   = 1'b1;

        // 1: basic 4-beat frame and commit-to-valid latency
        do_reset();
        check_zero("reset");
        send_frame(4, 32'h1, 2'b11, 4'hF, 1'b1, 1'b1);
        idle(1);
        check("t1_lat1", 64'(bus.mAxiTvalid), 64'd0);
        idle(1);
        check("t1_lat2", 64'(bus.mAxiTvalid), 64'd0);
        idle(1);
        check("t1_lat3", 64'(bus.mAxiTvalid), 64'd1);
        drain("t1", 100);
        check("t1_good", 64'(goodCount), 64'd1);
        check("t1_level", 64'(bufLevel), 64'd0);

        // 2: CRC-failed frame discarded, following good frame passes
        do_reset();
        send_frame(3, 32'h100, 2'b10, 4'hF, 1'b0, 1'b1);
        send_frame(2, 32'h200, 2'b11, 4'h7, 1'b1, 1'b1);
        drain("t2", 100);
        check("t2_crc", 64'(crcErrCount), 64'd1);
        check("t2_good", 64'(goodCount), 64'd1);
        check("t2_drop", 64'(dropCount), 64'd0);

        // 3: overflow with output stalled
        do_reset();
        bus.mAxiTready = 1'b0;
        send_frame(10, 32'h300, 2'b11, 4'hF, 1'b1, 1'b1);
        send_frame(8, 32'h400, 2'b11, 4'hF, 1'b0, 1'b1);
        idle(4);
        check("t3_drop", 64'(dropCount), 64'd1);
        check("t3_good", 64'(goodCount), 64'd1);
        check("t3_level", 64'(bufLevel), 64'd10);
        check("t3_valid", 64'(bus.mAxiTvalid), 64'd1);
        check("t3_head", 64'(bus.mAxiTdata), 64'h300);
        bus.mAxiTready = 1'b1;
        drain("t3", 100);
        check("t3_level_end", 64'(bufLevel), 64'd0);

        // 4: frame longer than the buffer, then a normal frame
        do_reset();
        send_frame(20, 32'h500, 2'b11, 4'hF, 1'b0, 1'b1);
        idle(3);
        check("t4_drop", 64'(dropCount), 64'd1);
        check("t4_level", 64'(bufLevel), 64'd0);
        check("t4_good0", 64'(goodCount), 64'd0);
        send_frame(3, 32'h600, 2'b11, 4'h1, 1'b1, 1'b1);
        drain("t4", 100);
        check("t4_good", 64'(goodCount), 64'd1);
        check("t4_drop_end", 64'(dropCount), 64'd1);

        // 5: random back-to-back frames with random ready, sized to never overflow
        do_reset();
        exp_good = 0;
        exp_bad  = 0;
        cyc      = 0;
        rand_rdy = 1'b1;
        while (cyc < 10000) begin
            int len, w;
            bit bad;
            len = $urandom_range(1, 8);
            bad = ($urandom_range(0, 4) == 0);
            w = 0;
            while (exp_q.size() + len > DEPTH && w < 200) begin
                idle(1);
                w++;
            end
            if (w >= 200) begin
                check("t5_space_wait", 64'(exp_q.size()), 64'(DEPTH - len));
                break;
            end
            send_frame(len, $urandom, bad ? 2'($urandom_range(0, 2)) : 2'b11,
                       4'($urandom_range(1, 15)), !bad, 1'b1);
            if (bad) exp_bad++;
            else exp_good++;
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rand_rdy = 1'b0;
        bus.mAxiTready = 1'b1;
        drain("t5", 200);
        check("t5_good", 64'(goodCount), 64'(exp_good));
        check("t5_crc", 64'(crcErrCount), 64'(exp_bad));
        check("t5_drop", 64'(dropCount), 64'd0);

        // 6: reset during readout with a partial frame in flight
        do_reset();
        bus.mAxiTready = 1'b0;
        send_frame(4, 32'h800, 2'b11, 4'hF, 1'b1, 1'b1);
        send_frame(3, 32'h900, 2'b11, 4'hF, 1'b0, 1'b0);
        check("t6_pre_good", 64'(goodCount), 64'd1);
        check("t6_pre_level", 64'(bufLevel), 64'd4);
        do_reset();
        check_zero("t6_reset");
        bus.mAxiTready = 1'b1;
        send_frame(1, 32'hCAFE0001, 2'b11, 4'h3, 1'b1, 1'b1);
        drain("t6", 100);
        check("t6_good", 64'(goodCount), 64'd1);

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
